mips_fetch_ctrl: RTL and testbench
==================================

Name: mips_fetch_ctrl

Overview:
Instruction-fetch sequencer for the pipelined MIPS core. It owns the PC and drives word-aligned addresses into the combinational instruction ROM (zero-latency, 64 words). Each fetched word is buffered with its PC in a 2-entry queue and handed to decode over a valid/ready handshake. Branch/jump redirects flush the queue and reload the PC; misaligned or out-of-range fetches halt fetching and raise an error code.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset
ROM_WORDS, 64, number of valid ROM words; fetch addresses at or above ROM_WORDS*4 (relative to RESET_PC's 256-byte region base) are out of range
QDEPTH, 2, fetch queue depth (fixed at 2; a parameter for documentation only)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high reset
rom_addr  out  32  byte address to the instruction ROM; equals the current PC
rom_data  in  32  ROM word for rom_addr, valid in the same cycle
redirect_valid  in  1  branch/jump taken this cycle
redirect_pc  in  32  target byte address
instr_valid  out  1  queue head valid
instr  out  32  queue head instruction word
instr_pc  out  32  queue head PC
instr_ready  in  1  decode accepts the head this cycle
fetch_err  out  2  0 = none, 1 = misaligned redirect, 2 = PC out of range

Behaviour:
- Reset (synchronous, one edge): pc=RESET_PC, queue empty, state=FETCH, instr_valid=0, instr=0, instr_pc=0, fetch_err=0. Reset overrides every other input.
- States: FETCH, HALT_ERR.
- Push in FETCH when the queue is not full or a pop happens in the same cycle: enqueue {pc, rom_data}, then pc += 4 (32-bit wrap).
- Pop: instr_valid && instr_ready. Simultaneous push and pop with the queue full is legal; count stays 2.
- Latency: an address presented at cycle N appears at the queue head at cycle N+1. After reset, first instr_valid=1 occurs in the 2nd cycle after reset deasserts.
- When the queue is full and there is no pop: no push, pc holds, and rom_addr holds.
- Redirect (highest priority after reset):
  - Flush the queue and set pc=redirect_pc; no push in that cycle.
  - A pop in the same cycle is completed for the consumer; all other entries are discarded.
  - instr_valid=0 on the next cycle. The first target instruction is valid the cycle after that.
- Misaligned redirect (redirect_pc[1:0]!=0): flush, state=HALT_ERR, fetch_err=1, pc=redirect_pc (held, not fetched).
- Out of range (pc word offset >= ROM_WORDS while in FETCH): no push, state=HALT_ERR, fetch_err=2. Entries already queued still drain normally.
- In HALT_ERR: no pushes; rom_addr holds. An aligned redirect returns to FETCH, clears fetch_err, and follows normal redirect rules. A misaligned redirect stays in HALT_ERR with fetch_err=1.
- rom_addr is always word-aligned in FETCH. The ROM's unaligned-address diagnostic must never fire during normal operation.
- Queue outputs are registered. instr/instr_pc hold their last value when instr_valid=0; benches must not check them then.

Decomposition:
- Package mips_fetch_pkg holds:
  - typedef fetch_state_t {FETCH, HALT_ERR}
  - fetch_err_t codes ERR_NONE=0, ERR_MISALIGN=1, ERR_RANGE=2
  - constant INSTR_BYTES=4
- Sub-module fetch_queue: 2-entry, 64-bit-wide synchronous FIFO with push, pop, flush, full, empty, head. The controller instantiates it and owns the PC, FSM and error logic.

Test Plan:
1. Reset, instr_ready=1 continuously -> from cycle 2: instr_pc 0x0,0x4,0x8,0xC,0x10 with instr 8c020004, 0, 0, 0, 00421020; one instruction per cycle.
2. instr_ready=0 for 6 cycles after reset -> queue holds pc 0x0 and 0x4, rom_addr stays 0x8, head stays 8c020004. Raise ready -> heads 0x0, 0x4, 0x8 on consecutive cycles, with no gap or duplicate.
3. Redirect to 0x34 at cycle 4 with ready=1 -> instr_valid=0 for one cycle, then instr_pc=0x34 with instr=00421020, then 0x38. No pre-redirect PC appears after the flush.
4. Redirect to 0x36 -> fetch_err=1, instr_valid=0, rom_addr constant for 5 cycles. Redirect to 0x0 -> fetch_err=0, and instr_pc=0x0 valid two cycles later.
5. ROM_WORDS=18, ready=1 -> last valid instr_pc=0x44, fetch_err=2 when pc=0x48, no further instr_valid.
6. Assert reset with the queue full and ready=0 -> next cycle instr_valid=0, rom_addr=RESET_PC, fetch_err=0; normal fetch resumes as in scenario 1.

Source files
------------

// File: rtl/mips_fetch_pkg.sv
// Shared types for the MIPS fetch sequencer.
// Holds FSM states, error codes and the queued fetch entry.
package mips_fetch_pkg;

  typedef enum logic {
    FETCH    = 1'b0,
    HALT_ERR = 1'b1
  } fetch_state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_MISALIGN = 2'd1,
    ERR_RANGE    = 2'd2
  } fetch_err_t;

  localparam logic [31:0] INSTR_BYTES = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fq_entry_t;

endpackage

// File: rtl/mips_fetch_queue.sv
// Two-entry shift FIFO of {pc, instr} with registered head.
// The head holds its last value once the queue drains.
module fetch_queue
  import mips_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      reset_i,
  input  logic      push_i,
  input  logic      pop_i,
  input  logic      flush_i,
  input  fq_entry_t data_i,
  output logic      full_o,
  output logic      empty_o,
  output fq_entry_t head_o
);

  localparam logic [1:0] FULL_CNT = 2'(DEPTH);

  fq_entry_t  e0_q;
  fq_entry_t  e1_q;
  logic [1:0] cnt_q;
  logic       do_pop;

  assign do_pop  = pop_i && (cnt_q != 2'd0);
  assign full_o  = (cnt_q == FULL_CNT);
  assign empty_o = (cnt_q == 2'd0);
  assign head_o  = e0_q;

  always_ff @(posedge clk) begin
    if (reset_i) begin
      cnt_q <= 2'd0;
      e0_q  <= '0;
      e1_q  <= '0;
    end else if (flush_i) begin
      cnt_q <= 2'd0;
    end else begin
      case ({push_i, do_pop})
        2'b10: begin
          if (cnt_q == 2'd0) e0_q <= data_i;
          else               e1_q <= data_i;
          cnt_q <= cnt_q + 2'd1;
        end
        2'b01: begin
          if (cnt_q == 2'd2) e0_q <= e1_q;
          cnt_q <= cnt_q - 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd1) begin
            e0_q <= data_i;
          end else begin
            e0_q <= e1_q;
            e1_q <= data_i;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mips_fetch_ctrl.sv
// MIPS fetch sequencer: owns the PC, fetch FSM and error state,
// and feeds a 2-entry queue toward decode.
module mips_fetch_ctrl
  import mips_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          ROM_WORDS = 64,
  parameter int          QDEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  output logic [1:0]  fetch_err
);

  localparam logic [31:0] BASE  = RESET_PC & 32'hFFFF_FF00;
  localparam logic [31:0] LIMIT = 32'(ROM_WORDS) * INSTR_BYTES;

  fetch_state_t state_q;
  fetch_err_t   err_q;
  logic [31:0]  pc_q;

  logic      q_full;
  logic      q_empty;
  logic      pop;
  logic      in_range;
  logic      can_push;
  logic      flush;
  fq_entry_t q_head;
  fq_entry_t q_din;

  assign rom_addr    = pc_q;
  assign instr_valid = !q_empty;
  assign instr       = q_head.instr;
  assign instr_pc    = q_head.pc;
  assign fetch_err   = err_q;

  assign pop      = instr_valid && instr_ready;
  assign in_range = (pc_q - BASE) < LIMIT;
  assign flush    = redirect_valid;
  assign can_push = (state_q == FETCH) && in_range &&
                    !redirect_valid && (!q_full || pop);
  assign q_din    = '{pc: pc_q, instr: rom_data};

  fetch_queue #(
    .DEPTH (QDEPTH)
  ) u_queue (
    .clk     (clk),
    .reset_i (reset),
    .push_i  (can_push),
    .pop_i   (pop),
    .flush_i (flush),
    .data_i  (q_din),
    .full_o  (q_full),
    .empty_o (q_empty),
    .head_o  (q_head)
  );

  // Redirect outranks range checking so a halted core can be restarted.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      state_q <= FETCH;
      err_q   <= ERR_NONE;
    end else if (redirect_valid) begin
      pc_q <= redirect_pc;
      if (redirect_pc[1:0] != 2'b00) begin
        state_q <= HALT_ERR;
        err_q   <= ERR_MISALIGN;
      end else begin
        state_q <= FETCH;
        err_q   <= ERR_NONE;
      end
    end else if ((state_q == FETCH) && !in_range) begin
      state_q <= HALT_ERR;
      err_q   <= ERR_RANGE;
    end else if (can_push) begin
      pc_q <= pc_q + INSTR_BYTES;
    end
  end

endmodule

// File: tb/tb_mips_fetch_ctrl.sv
// Scoreboard bench for mips_fetch_ctrl: directed scenarios push
// expected {pc,instr} pairs; monitors pop and compare on handshakes.
module tb_mips_fetch_ctrl;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready = 1'b0;
  logic [1:0]  fetch_err;

  logic        reset2 = 1'b1;
  logic [31:0] rom_addr2;
  logic [31:0] rom_data2;
  logic        rv2 = 1'b0;
  logic [31:0] rpc2 = 32'h0;
  logic        instr_valid2;
  logic [31:0] instr2;
  logic [31:0] instr_pc2;
  logic        ready2 = 1'b0;
  logic [1:0]  fetch_err2;

  ent_t exp_q[$];
  ent_t exp2_q[$];
  ent_t m_e;
  ent_t m_e2;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    logic [5:0] idx;
    idx = a[7:2];
    if (a >= 32'd256) return 32'hDEAD_BEEF;
    case (idx)
      6'd0:          return 32'h8c02_0004;
      6'd1, 6'd2,
      6'd3:          return 32'h0000_0000;
      6'd4, 6'd13:   return 32'h0042_1020;
      default:       return 32'h2400_0000 | {26'd0, idx};
    endcase
  endfunction

  assign rom_data  = rom_word(rom_addr);
  assign rom_data2 = rom_word(rom_addr2);

  mips_fetch_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready),
    .fetch_err      (fetch_err)
  );

  mips_fetch_ctrl #(
    .ROM_WORDS (18)
  ) dut18 (
    .clk            (clk),
    .reset          (reset2),
    .rom_addr       (rom_addr2),
    .rom_data       (rom_data2),
    .redirect_valid (rv2),
    .redirect_pc    (rpc2),
    .instr_valid    (instr_valid2),
    .instr          (instr2),
    .instr_pc       (instr_pc2),
    .instr_ready    (ready2),
    .fetch_err      (fetch_err2)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, expv);
    end
  endtask

  task automatic expect_ent(input logic [31:0] pc, input logic [31:0] ins);
    exp_q.push_back('{pc: pc, ins: ins});
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    exp_q.delete();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!reset && instr_valid && instr_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL pop_unexpected: got pc %h, none expected", instr_pc);
      end else begin
        m_e = exp_q.pop_front();
        chk("head_pc", instr_pc, m_e.pc);
        chk("head_instr", instr, m_e.ins);
      end
    end
    if (!reset && fetch_err == 2'd0 && rom_addr[1:0] != 2'b00) begin
      n_bad++;
      $display("FAIL rom_unaligned: got %h, expected word aligned", rom_addr);
    end
  end

  always @(negedge clk) begin
    if (!reset2 && instr_valid2 && ready2) begin
      if (exp2_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL pop_unexpected18: got pc %h, none expected",
                 instr_pc2);
      end else begin
        m_e2 = exp2_q.pop_front();
        chk("head_pc18", instr_pc2, m_e2.pc);
        chk("head_instr18", instr2, m_e2.ins);
      end
    end
    if (!reset2 && fetch_err2 == 2'd0 && rom_addr2[1:0] != 2'b00) begin
      n_bad++;
      $display("FAIL rom_unaligned18: got %h, expected aligned", rom_addr2);
    end
  end

  initial begin
    // Scenario 1: free-running fetch after reset
    do_reset();
    instr_ready = 1'b1;
    expect_ent(32'h00, 32'h8c02_0004);
    expect_ent(32'h04, 32'h0000_0000);
    expect_ent(32'h08, 32'h0000_0000);
    expect_ent(32'h0C, 32'h0000_0000);
    expect_ent(32'h10, 32'h0042_1020);
    @(negedge clk);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_instr_pc", instr_pc, 32'd0);
    chk("rst_err", {30'd0, fetch_err}, 32'd0);
    chk("rst_rom_addr", rom_addr, 32'd0);
    repeat (6) @(posedge clk);
    #1 instr_ready = 1'b0;
    @(negedge clk);
    chk("s1_drained", exp_q.size(), 32'd0);

    // Scenario 2: backpressure fills the queue, then release
    do_reset();
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("s2_rom_hold", rom_addr, 32'h08);
    chk("s2_valid", {31'd0, instr_valid}, 32'd1);
    chk("s2_head_pc", instr_pc, 32'h00);
    chk("s2_head", instr, 32'h8c02_0004);
    expect_ent(32'h00, 32'h8c02_0004);
    expect_ent(32'h04, 32'h0000_0000);
    expect_ent(32'h08, 32'h0000_0000);
    @(posedge clk);
    #1 instr_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 instr_ready = 1'b0;
    @(negedge clk);
    chk("s2_drained", exp_q.size(), 32'd0);

    // Scenario 3: aligned redirect at cycle 4
    do_reset();
    instr_ready = 1'b1;
    expect_ent(32'h00, 32'h8c02_0004);
    expect_ent(32'h04, 32'h0000_0000);
    expect_ent(32'h08, 32'h0000_0000);
    expect_ent(32'h34, 32'h0042_1020);
    expect_ent(32'h38, 32'h2400_000E);
    repeat (3) @(posedge clk);
    #1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h34;
    @(posedge clk);
    #1 redirect_valid = 1'b0;
    @(negedge clk);
    chk("s3_bubble", {31'd0, instr_valid}, 32'd0);
    repeat (3) @(posedge clk);
    #1 instr_ready = 1'b0;
    @(negedge clk);
    chk("s3_drained", exp_q.size(), 32'd0);

    // Scenario 4: misaligned redirect halts, aligned one restarts
    do_reset();
    instr_ready    = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h36;
    @(posedge clk);
    #1 redirect_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("s4_err", {30'd0, fetch_err}, 32'd1);
      chk("s4_valid", {31'd0, instr_valid}, 32'd0);
      chk("s4_rom_hold", rom_addr, 32'h36);
    end
    expect_ent(32'h00, 32'h8c02_0004);
    @(posedge clk);
    #1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0;
    @(posedge clk);
    #1 redirect_valid = 1'b0;
    @(negedge clk);
    chk("s4_err_clr", {30'd0, fetch_err}, 32'd0);
    chk("s4_bubble", {31'd0, instr_valid}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 instr_ready = 1'b0;
    @(negedge clk);
    chk("s4_drained", exp_q.size(), 32'd0);

    // Scenario 6: reset with a full, stalled queue
    do_reset();
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("s6_full_hold", rom_addr, 32'h08);
    do_reset();
    @(negedge clk);
    chk("s6_valid", {31'd0, instr_valid}, 32'd0);
    chk("s6_rom_addr", rom_addr, 32'h0);
    chk("s6_err", {30'd0, fetch_err}, 32'd0);
    expect_ent(32'h00, 32'h8c02_0004);
    expect_ent(32'h04, 32'h0000_0000);
    expect_ent(32'h08, 32'h0000_0000);
    #1 instr_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1 instr_ready = 1'b0;
    @(negedge clk);
    chk("s6_drained", exp_q.size(), 32'd0);

    // Scenario 5: 18-word ROM runs off the end
    for (int i = 0; i < 18; i++) begin
      exp2_q.push_back('{pc: 32'(i * 4), ins: rom_word(32'(i * 4))});
    end
    @(posedge clk);
    #1;
    ready2 = 1'b1;
    reset2 = 1'b0;
    repeat (30) @(posedge clk);
    @(negedge clk);
    chk("s5_err", {30'd0, fetch_err2}, 32'd2);
    chk("s5_valid", {31'd0, instr_valid2}, 32'd0);
    chk("s5_rom_addr", rom_addr2, 32'h48);
    chk("s5_drained", exp2_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
